// File: rtl/ysyx_25040109_trap_seq.sv
// CSR/trap sequencer: turns ecall, mret and Zicsr requests into
// ordered single-write-per-cycle CSR transactions plus PC redirects.
module ysyx_25040109_trap_seq #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 32'd11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  req_ready,
   input  logic                  trap_valid,
   input  logic [DATA_WIDTH-1:0] trap_pc,
   input  logic                  mret_valid,
   input  logic                  csr_valid,
   input  logic [1:0]            csr_op,
   input  logic [11:0]           csr_op_addr,
   input  logic [DATA_WIDTH-1:0] csr_op_src,
   input  logic                  csr_op_nowr,
   output logic                  csr_we,
   output logic [11:0]           csr_addr,
   output logic [DATA_WIDTH-1:0] csr_wdata,
   input  logic [DATA_WIDTH-1:0] csr_rdata,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  csr_done,
   output logic [DATA_WIDTH-1:0] csr_old
);

   typedef enum logic [2:0] {
      IDLE, T_MEPC, T_MCAUSE, T_MSTAT,
      T_JUMP, R_MSTAT, R_JUMP, C_RMW
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] pc_lat;
   logic [1:0]            op_lat;
   logic [11:0]           addr_lat;
   logic [DATA_WIDTH-1:0] src_lat;
   logic                  nowr_lat;

   logic [DATA_WIDTH-1:0] mstat_trap;
   logic [DATA_WIDTH-1:0] mstat_ret;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Capture request operands on accept; only the winning request latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_lat   <= '0;
         op_lat   <= 2'b00;
         addr_lat <= 12'h000;
         src_lat  <= '0;
         nowr_lat <= 1'b0;
      end else if (state == IDLE) begin
         if (trap_valid) begin
            pc_lat <= trap_pc;
         end else if (!mret_valid && csr_valid) begin
            op_lat   <= csr_op;
            addr_lat <= csr_op_addr;
            src_lat  <= csr_op_src;
            nowr_lat <= csr_op_nowr;
         end
      end
   end

   // Next-state: fixed sequences, priority trap > mret > csr in IDLE
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (trap_valid)      state_next = T_MEPC;
            else if (mret_valid) state_next = R_MSTAT;
            else if (csr_valid)  state_next = C_RMW;
         end
         T_MEPC:   state_next = T_MCAUSE;
         T_MCAUSE: state_next = T_MSTAT;
         T_MSTAT:  state_next = T_JUMP;
         T_JUMP:   state_next = IDLE;
         R_MSTAT:  state_next = R_JUMP;
         R_JUMP:   state_next = IDLE;
         C_RMW:    state_next = IDLE;
      endcase
   end

   // mstatus edits: trap stacks MIE into MPIE, mret restores it
   always_comb begin
      mstat_trap        = csr_rdata;
      mstat_trap[7]     = csr_rdata[3];
      mstat_trap[3]     = 1'b0;
      mstat_trap[12:11] = 2'b11;
      mstat_ret         = csr_rdata;
      mstat_ret[3]      = csr_rdata[7];
      mstat_ret[7]      = 1'b1;
      mstat_ret[12:11]  = 2'b00;
   end

   // Outputs decoded from state and latched operands
   always_comb begin
      req_ready      = 1'b0;
      csr_we         = 1'b0;
      csr_addr       = 12'h000;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      csr_done       = 1'b0;
      csr_old        = '0;
      unique case (state)
         IDLE: req_ready = 1'b1;
         T_MEPC: begin
            csr_we    = 1'b1;
            csr_addr  = 12'h341;
            csr_wdata = pc_lat;
         end
         T_MCAUSE: begin
            csr_we    = 1'b1;
            csr_addr  = 12'h342;
            csr_wdata = ECALL_CAUSE;
         end
         T_MSTAT: begin
            csr_we    = 1'b1;
            csr_addr  = 12'h300;
            csr_wdata = mstat_trap;
         end
         T_JUMP: begin
            csr_addr       = 12'h305;
            redirect_valid = 1'b1;
            redirect_pc    = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
         end
         R_MSTAT: begin
            csr_we    = 1'b1;
            csr_addr  = 12'h300;
            csr_wdata = mstat_ret;
         end
         R_JUMP: begin
            csr_addr       = 12'h341;
            redirect_valid = 1'b1;
            redirect_pc    = csr_rdata;
         end
         C_RMW: begin
            csr_addr = addr_lat;
            csr_old  = csr_rdata;
            csr_done = 1'b1;
            unique case (op_lat)
               2'b01: begin
                  csr_we    = 1'b1;
                  csr_wdata = src_lat;
               end
               2'b10: begin
                  csr_we    = !nowr_lat;
                  csr_wdata = csr_rdata | src_lat;
               end
               2'b11: begin
                  csr_we    = !nowr_lat;
                  csr_wdata = csr_rdata & ~src_lat;
               end
               2'b00: begin
                  csr_we    = 1'b0;
                  csr_wdata = '0;
               end
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_25040109_trap_seq.sv
// Bench for ysyx_25040109_trap_seq with a small CSR bank model
// (mstatus, mtvec, mepc, mcause; other addresses read 0, drop writes).
module tb_ysyx_25040109_trap_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_ready;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = '0;
   logic        mret_valid = 1'b0;
   logic        csr_valid = 1'b0;
   logic [1:0]  csr_op = 2'b00;
   logic [11:0] csr_op_addr = '0;
   logic [31:0] csr_op_src = '0;
   logic        csr_op_nowr = 1'b0;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        csr_done;
   logic [31:0] csr_old;

   int total = 0;
   int bad = 0;

   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   ysyx_25040109_trap_seq dut (
      .clk(clk), .rst_n(rst_n), .req_ready(req_ready),
      .trap_valid(trap_valid), .trap_pc(trap_pc),
      .mret_valid(mret_valid), .csr_valid(csr_valid),
      .csr_op(csr_op), .csr_op_addr(csr_op_addr),
      .csr_op_src(csr_op_src), .csr_op_nowr(csr_op_nowr),
      .csr_we(csr_we), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .csr_done(csr_done), .csr_old(csr_old)
   );

   always #5 clk = ~clk;

   // Combinational read port of the CSR bank model
   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         12'h300: csr_rdata = m_mstatus;
         12'h305: csr_rdata = m_mtvec;
         12'h341: csr_rdata = m_mepc;
         12'h342: csr_rdata = m_mcause;
         default: csr_rdata = '0;
      endcase
   end

   // Write port of the bank model; bench preload shares the same process
   always @(posedge clk) begin
      if (pl_en || csr_we) begin
         case (pl_en ? pl_addr : csr_addr)
            12'h300: m_mstatus <= pl_en ? pl_data : csr_wdata;
            12'h305: m_mtvec   <= pl_en ? pl_data : csr_wdata;
            12'h341: m_mepc    <= pl_en ? pl_data : csr_wdata;
            12'h342: m_mcause  <= pl_en ? pl_data : csr_wdata;
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] bank_rd(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Ecall sequence; optionally also raises mret/csr to test priority
   task automatic run_ecall(input logic [31:0] pc, input logic [31:0] exp_mst,
                            input logic [31:0] exp_pc, input logic all_req);
      @(negedge clk);
      chk("ecall_ready_before", req_ready, 1);
      trap_valid = 1'b1; trap_pc = pc;
      if (all_req) begin
         mret_valid = 1'b1; csr_valid = 1'b1;
         csr_op = 2'b01; csr_op_addr = 12'h300; csr_op_src = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      trap_valid = 1'b0; mret_valid = 1'b0; csr_valid = 1'b0;
      chk("t_mepc_ready", req_ready, 0);
      chk("t_mepc_we", csr_we, 1);
      chk("t_mepc_addr", csr_addr, 32'h341);
      chk("t_mepc_wdata", csr_wdata, pc);
      chk("t_mepc_done", csr_done, 0);
      @(negedge clk);
      chk("t_mcause_we", csr_we, 1);
      chk("t_mcause_addr", csr_addr, 32'h342);
      chk("t_mcause_wdata", csr_wdata, 32'd11);
      @(negedge clk);
      chk("t_mstat_we", csr_we, 1);
      chk("t_mstat_addr", csr_addr, 32'h300);
      chk("t_mstat_wdata", csr_wdata, exp_mst);
      chk("t_mstat_redir", redirect_valid, 0);
      @(negedge clk);
      chk("t_jump_we", csr_we, 0);
      chk("t_jump_redir", redirect_valid, 1);
      chk("t_jump_pc", redirect_pc, exp_pc);
      chk("t_jump_ready", req_ready, 0);
      @(negedge clk);
      chk("t_after_redir", redirect_valid, 0);
      chk("t_after_ready", req_ready, 1);
      chk("t_after_we", csr_we, 0);
      chk("t_mepc_val", m_mepc, pc);
      chk("t_mcause_val", m_mcause, 32'd11);
      chk("t_mstatus_val", m_mstatus, exp_mst);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] src;
      logic        nowr;
      logic [31:0] init;
      logic [31:0] old;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] after;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{2'b10, 12'h305, 32'h0F, 1'b0, 32'h100, 32'h100, 1'b1, 32'h10F, 32'h10F};
      vecs[1] = '{2'b10, 12'h305, 32'h0F, 1'b1, 32'h100, 32'h100, 1'b0, 32'h0, 32'h100};
      vecs[2] = '{2'b11, 12'h300, 32'h08, 1'b0, 32'h1888, 32'h1888, 1'b1, 32'h1880, 32'h1880};
      vecs[3] = '{2'b01, 12'h341, 32'h1234, 1'b1, 32'h0, 32'h0, 1'b1, 32'h1234, 32'h1234};
      vecs[4] = '{2'b00, 12'h342, 32'hFFFF, 1'b0, 32'h7, 32'h7, 1'b0, 32'h0, 32'h7};
      vecs[5] = '{2'b11, 12'h305, 32'hF0F0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b0, 32'h0, 32'hFFFF};
      vecs[6] = '{2'b01, 12'h7C0, 32'hDEAD, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD, 32'h0};

      #2;
      chk("rst_ready", req_ready, 1);
      chk("rst_we", csr_we, 0);
      chk("rst_redir", redirect_valid, 0);
      chk("rst_done", csr_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1: basic ecall
      set_csr(12'h300, 32'h1808);
      set_csr(12'h305, 32'h8000_0101);
      run_ecall(32'h8000_0010, 32'h1880, 32'h8000_0100, 1'b0);

      // Scenario 2: mret
      set_csr(12'h341, 32'h8000_0014);
      set_csr(12'h300, 32'h1880);
      @(negedge clk);
      mret_valid = 1'b1;
      @(negedge clk);
      mret_valid = 1'b0;
      chk("r_mstat_we", csr_we, 1);
      chk("r_mstat_addr", csr_addr, 32'h300);
      chk("r_mstat_wdata", csr_wdata, 32'h0088);
      chk("r_mstat_ready", req_ready, 0);
      @(negedge clk);
      chk("r_jump_we", csr_we, 0);
      chk("r_jump_redir", redirect_valid, 1);
      chk("r_jump_pc", redirect_pc, 32'h8000_0014);
      @(negedge clk);
      chk("r_after_redir", redirect_valid, 0);
      chk("r_after_ready", req_ready, 1);
      chk("r_mstatus_val", m_mstatus, 32'h0088);
      chk("r_mepc_val", m_mepc, 32'h8000_0014);

      // Zicsr table
      for (int i = 0; i < 7; i++) begin
         set_csr(vecs[i].addr, vecs[i].init);
         @(negedge clk);
         csr_valid = 1'b1; csr_op = vecs[i].op;
         csr_op_addr = vecs[i].addr; csr_op_src = vecs[i].src;
         csr_op_nowr = vecs[i].nowr;
         @(negedge clk);
         csr_valid = 1'b0;
         chk($sformatf("v%0d_done", i), csr_done, 1);
         chk($sformatf("v%0d_old", i), csr_old, vecs[i].old);
         chk($sformatf("v%0d_we", i), csr_we, vecs[i].we);
         chk($sformatf("v%0d_addr", i), csr_addr, vecs[i].addr);
         if (vecs[i].we)
            chk($sformatf("v%0d_wdata", i), csr_wdata, vecs[i].wdata);
         chk($sformatf("v%0d_ready", i), req_ready, 0);
         @(negedge clk);
         chk($sformatf("v%0d_done_clr", i), csr_done, 0);
         chk($sformatf("v%0d_ready_back", i), req_ready, 1);
         chk($sformatf("v%0d_after", i), bank_rd(vecs[i].addr), vecs[i].after);
      end

      // Ecall after unimplemented-CSR write behaves as scenario 1
      set_csr(12'h300, 32'h1808);
      set_csr(12'h305, 32'h8000_0101);
      run_ecall(32'h8000_0010, 32'h1880, 32'h8000_0100, 1'b0);

      // Priority: trap wins over mret and csr
      set_csr(12'h300, 32'h1808);
      run_ecall(32'h8000_0040, 32'h1880, 32'h8000_0100, 1'b1);
      @(negedge clk);
      chk("prio_idle_we", csr_we, 0);
      chk("prio_mstatus", m_mstatus, 32'h1880);

      // Reset during T_MCAUSE
      set_csr(12'h342, 32'h55);
      @(negedge clk);
      trap_valid = 1'b1; trap_pc = 32'h8000_0020;
      @(negedge clk);
      trap_valid = 1'b0;
      @(negedge clk);
      chk("rm_in_mcause", csr_addr, 32'h342);
      rst_n = 1'b0;
      #1;
      chk("rm_ready", req_ready, 1);
      chk("rm_we", csr_we, 0);
      chk("rm_redir", redirect_valid, 0);
      @(negedge clk);
      chk("rm_redir2", redirect_valid, 0);
      chk("rm_mepc", m_mepc, 32'h8000_0020);
      chk("rm_mcause", m_mcause, 32'h55);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rm_ready_after", req_ready, 1);
      chk("rm_we_after", csr_we, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
